// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
//   Owns the fetch PC, drives the instruction-memory request handshake and
//   sequences control-flow redirects resolved by the EX-stage branch unit.
//   On a redirect it flushes IF/ID and ID/EX, and it discards the fetch that
//   was already in flight.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   stall          hazard freeze: holds PC, drops fetch request, blocks redirect
//   br_valid       EX stage holds a valid instruction
//   branch_type    {auipc, jal, jalr, btype_taken}
//   ex_pc, ex_imm  EX-stage PC and sign-extended immediate
//   rs1_data       forwarded rs1 (jalr base)
//   imem_req/addr  fetch request and address (address = pc_o)
//   imem_ready     memory accepts the request when imem_req & imem_ready
//   pc_o           current fetch PC
//   flush_if/id    kill the IF/ID or ID/EX register contents
//   redirect_o     one-cycle pulse when a redirect is taken
//   misalign_o     (MISALIGN_TRAP_EN only) misaligned redirect target
//
// Build option
//   MISALIGN_TRAP_EN : if defined, a redirect target with target[1:0] != 0
//   is not taken; the pipeline is flushed and misalign_o pulses instead.
//   If undefined, target[1] is honoured as is (compressed-ISA friendly).

module pc_redirect_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_valid,
  input  logic [3:0]      branch_type,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] rs1_data,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc_o,
  output logic            flush_if,
  output logic            flush_id,
  output logic            redirect_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            misalign_o
`endif
);

  typedef enum logic {RUN, WAIT_ACK} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] jalr_sum;
  logic            take;
  logic            fire;
  logic            bad_align;

  // Redirect target: jalr has priority and clears bit 0; jal and btype share
  // the PC-relative form. All adds wrap modulo 2^XLEN.
  always_comb begin
    jalr_sum = rs1_data + ex_imm;
    if (branch_type[1])
      target = {jalr_sum[XLEN-1:1], 1'b0};
    else
      target = ex_pc + ex_imm;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    drop_d     = 1'b0;
    imem_req   = 1'b0;
    flush_if   = 1'b0;
    flush_id   = 1'b0;
    redirect_o = 1'b0;
    take       = 1'b0;
    fire       = 1'b0;
    bad_align  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misalign_o = 1'b0;
`endif

    case (state_q)
      RUN: begin
        imem_req = ~stall;
        fire     = imem_req & imem_ready;
        // auipc (bit 3) never redirects.
        take     = br_valid & ~stall & (|branch_type[2:0]);
`ifdef MISALIGN_TRAP_EN
        bad_align = take & (|target[1:0]);
`endif
        if (bad_align) begin
          // Trap unit owns the redirect; just kill the wrong-path work.
`ifdef MISALIGN_TRAP_EN
          misalign_o = 1'b1;
`endif
          flush_if = 1'b1;
          flush_id = 1'b1;
          drop_d   = fire;
        end else if (take) begin
          flush_if   = 1'b1;
          flush_id   = 1'b1;
          redirect_o = 1'b1;
          if (imem_ready) begin
            // The fetch accepted this cycle is wrong-path: drop its response.
            pc_d   = target;
            drop_d = 1'b1;
          end else begin
            // A pending request must keep a stable address until accepted.
            tgt_d   = target;
            state_d = WAIT_ACK;
          end
        end else if (fire) begin
          pc_d = pc_q + XLEN'(4);
        end
      end

      WAIT_ACK: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          pc_d    = tgt_q;
          drop_d  = 1'b1;
          state_d = RUN;
        end
      end

      default: state_d = RUN;
    endcase

    // Response to a discarded fetch arrives this cycle.
    if (drop_q)
      flush_if = 1'b1;

    if (rst) begin
      imem_req   = 1'b0;
      flush_if   = 1'b0;
      flush_id   = 1'b0;
      redirect_o = 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_o = 1'b0;
`endif
    end
  end

  // State register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  // Latched redirect target (data, no reset needed)
  always_ff @(posedge clk) begin
    tgt_q <= tgt_d;
  end

  assign pc_o      = pc_q;
  assign imem_addr = pc_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed table-driven bench for pc_redirect_ctrl, plus a hand-written
// sequence for the misaligned / compressed redirect target.

module tb_pc_redirect_ctrl;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_valid;
  logic [3:0]  branch_type;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] rs1_data;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] pc_o;
  logic        flush_if;
  logic        flush_id;
  logic        redirect_o;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int n_vec = 0;
  int n_bad = 0;

  pc_redirect_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_valid   (br_valid),
    .branch_type(branch_type),
    .ex_pc      (ex_pc),
    .ex_imm     (ex_imm),
    .rs1_data   (rs1_data),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .pc_o       (pc_o),
    .flush_if   (flush_if),
    .flush_id   (flush_id),
    .redirect_o (redirect_o)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_o (misalign_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        bv;
    logic [3:0]  bt;
    logic [31:0] ex_pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        ready;
    logic        chk_pc;
    logic [31:0] e_pc;
    logic        e_req;
    logic        e_fif;
    logic        e_fid;
    logic        e_red;
  } vec_t;

  vec_t vq[$];

  task automatic drive(input vec_t v);
    rst         = v.rst;
    stall       = v.stall;
    br_valid    = v.bv;
    branch_type = v.bt;
    ex_pc       = v.ex_pc;
    ex_imm      = v.imm;
    rs1_data    = v.rs1;
    imem_ready  = v.ready;
  endtask

  task automatic check(input string nm, input vec_t v);
    logic bad;
    n_vec++;
    bad = (imem_req !== v.e_req) || (flush_if !== v.e_fif) ||
          (flush_id !== v.e_fid) || (redirect_o !== v.e_red) ||
          (v.chk_pc && ((pc_o !== v.e_pc) || (imem_addr !== v.e_pc)));
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got req=%b fif=%b fid=%b red=%b pc=%h addr=%h ; want req=%b fif=%b fid=%b red=%b pc=%h (pc checked=%b)",
               nm, imem_req, flush_if, flush_id, redirect_o, pc_o, imem_addr,
               v.e_req, v.e_fif, v.e_fid, v.e_red, v.e_pc, v.chk_pc);
    end
  endtask

  initial begin
    vec_t h;
    rst = 1'b1; stall = 1'b0; br_valid = 1'b0; branch_type = 4'h0;
    ex_pc = '0; ex_imm = '0; rs1_data = '0; imem_ready = 1'b1;

    //            rst stl bv  bt     ex_pc          imm            rs1           rdy chk e_pc           req fif fid red
    vq.push_back('{I, O, O, 4'h0, 32'h0,         32'h0,         32'h0,        I,  O,  32'h0,         O,  O,  O,  O}); // 0 reset
    vq.push_back('{O, O, O, 4'h0, 32'h0,         32'h0,         32'h0,        I,  I,  32'h0,         I,  O,  O,  O}); // 1
    vq.push_back('{O, O, O, 4'h0, 32'h0,         32'h0,         32'h0,        I,  I,  32'h4,         I,  O,  O,  O}); // 2
    vq.push_back('{O, O, O, 4'h0, 32'h0,         32'h0,         32'h0,        I,  I,  32'h8,         I,  O,  O,  O}); // 3
    vq.push_back('{O, O, O, 4'h0, 32'h0,         32'h0,         32'h0,        I,  I,  32'hC,         I,  O,  O,  O}); // 4
    vq.push_back('{O, O, I, 4'h1, 32'h100,       32'hFFFF_FFF0, 32'h0,        I,  I,  32'h10,        I,  I,  I,  I}); // 5 btype
    vq.push_back('{O, O, O, 4'h0, 32'h0,         32'h0,         32'h0,        I,  I,  32'hF0,        I,  I,  O,  O}); // 6 drop
    vq.push_back('{O, O, I, 4'h6, 32'h500,       32'h4,         32'h2001,     I,  I,  32'hF4,        I,  I,  I,  I}); // 7 jalr+jal
    vq.push_back('{O, O, O, 4'h0, 32'h0,         32'h0,         32'h0,        I,  I,  32'h2004,      I,  I,  O,  O}); // 8
    vq.push_back('{O, O, I, 4'h8, 32'h500,       32'h4,         32'h2001,     I,  I,  32'h2008,      I,  O,  O,  O}); // 9 auipc
    vq.push_back('{O, I, I, 4'h1, 32'h300,       32'h10,        32'h0,        I,  I,  32'h200C,      O,  O,  O,  O}); // 10 stall
    vq.push_back('{O, I, I, 4'h1, 32'h300,       32'h10,        32'h0,        I,  I,  32'h200C,      O,  O,  O,  O}); // 11 stall
    vq.push_back('{O, O, I, 4'h1, 32'h300,       32'h10,        32'h0,        I,  I,  32'h200C,      I,  I,  I,  I}); // 12 release
    vq.push_back('{O, O, O, 4'h0, 32'h0,         32'h0,         32'h0,        I,  I,  32'h310,       I,  I,  O,  O}); // 13
    vq.push_back('{O, O, I, 4'h4, 32'hFFFF_FFFC, 32'h8,         32'h0,        I,  I,  32'h314,       I,  I,  I,  I}); // 14 wrap
    vq.push_back('{O, O, O, 4'h0, 32'h0,         32'h0,         32'h0,        I,  I,  32'h4,         I,  I,  O,  O}); // 15
    vq.push_back('{O, O, O, 4'h0, 32'h0,         32'h0,         32'h0,        O,  I,  32'h8,         I,  O,  O,  O}); // 16 not ready
    vq.push_back('{O, O, O, 4'h0, 32'h0,         32'h0,         32'h0,        I,  I,  32'h8,         I,  O,  O,  O}); // 17
    vq.push_back('{O, O, I, 4'h1, 32'h400,       32'h40,        32'h0,        O,  I,  32'hC,         I,  I,  I,  I}); // 18 take, busy
    vq.push_back('{O, I, I, 4'h1, 32'h400,       32'h40,        32'h0,        O,  I,  32'hC,         I,  O,  O,  O}); // 19 wait
    vq.push_back('{O, O, O, 4'h0, 32'h0,         32'h0,         32'h0,        O,  I,  32'hC,         I,  O,  O,  O}); // 20 wait
    vq.push_back('{O, O, O, 4'h0, 32'h0,         32'h0,         32'h0,        I,  I,  32'hC,         I,  O,  O,  O}); // 21 ack
    vq.push_back('{O, O, O, 4'h0, 32'h0,         32'h0,         32'h0,        I,  I,  32'h440,       I,  I,  O,  O}); // 22 drop
    vq.push_back('{O, O, O, 4'h0, 32'h0,         32'h0,         32'h0,        I,  I,  32'h444,       I,  O,  O,  O}); // 23
    vq.push_back('{O, O, I, 4'h1, 32'h800,       32'h0,         32'h0,        O,  I,  32'h448,       I,  I,  I,  I}); // 24 take, busy
    vq.push_back('{I, O, O, 4'h0, 32'h0,         32'h0,         32'h0,        I,  I,  32'h448,       O,  O,  O,  O}); // 25 rst in wait
    vq.push_back('{O, O, O, 4'h0, 32'h0,         32'h0,         32'h0,        I,  I,  32'h0,         I,  O,  O,  O}); // 26
    vq.push_back('{O, O, O, 4'h0, 32'h0,         32'h0,         32'h0,        I,  I,  32'h4,         I,  O,  O,  O}); // 27

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      check($sformatf("vec%0d", i), vq[i]);
`ifdef MISALIGN_TRAP_EN
      n_vec++;
      if (misalign_o !== 1'b0) begin
        n_bad++;
        $display("FAIL vec%0d_misalign: got %b want 0", i, misalign_o);
      end
`endif
    end

    // Redirect target 0x102 (bit 1 set); pc_o is 0x8 at this point.
    @(negedge clk);
`ifdef MISALIGN_TRAP_EN
    h = '{O, O, I, 4'h1, 32'h100, 32'h2, 32'h0, I, I, 32'h8, I, I, I, O};
    drive(h); #1; check("misalign_take", h);
    n_vec++;
    if (misalign_o !== 1'b1) begin
      n_bad++;
      $display("FAIL misalign_pulse: got %b want 1", misalign_o);
    end
    @(negedge clk);
    h = '{O, O, O, 4'h0, 32'h0, 32'h0, 32'h0, I, I, 32'h8, I, I, O, O};
    drive(h); #1; check("misalign_hold", h);
    n_vec++;
    if (misalign_o !== 1'b0) begin
      n_bad++;
      $display("FAIL misalign_clear: got %b want 0", misalign_o);
    end
    @(negedge clk);
    h = '{O, O, O, 4'h0, 32'h0, 32'h0, 32'h0, I, I, 32'hC, I, O, O, O};
    drive(h); #1; check("misalign_resume", h);
`else
    h = '{O, O, I, 4'h1, 32'h100, 32'h2, 32'h0, I, I, 32'h8, I, I, I, I};
    drive(h); #1; check("half_take", h);
    @(negedge clk);
    h = '{O, O, O, 4'h0, 32'h0, 32'h0, 32'h0, I, I, 32'h102, I, I, O, O};
    drive(h); #1; check("half_target", h);
    @(negedge clk);
    h = '{O, O, O, 4'h0, 32'h0, 32'h0, 32'h0, I, I, 32'h106, I, O, O, O};
    drive(h); #1; check("half_next", h);
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
